// File: rtl/data_sram_bridge.sv
// data_sram_bridge: adapts the M-stage single-cycle SRAM-style data port
// to a split request/response bus (req/addr_ok then data_ok).
// The pipeline is held through stall_mem while a transaction is in flight.
// Optional build macro DATA_SRAM_BRIDGE_ALIGN_CHECK_EN adds misaligned
// access detection: adel/ades outputs, and no bus request is issued.
module data_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_enM,
    input  logic          memwriteM,
    input  logic [3:0]    sig_write,
    input  logic [1:0]    sizeM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic          stall_in,
    output logic [DW-1:0] readdataM,
    output logic          stall_mem,
    output logic          req,
    output logic          wr,
    output logic [1:0]    size,
    output logic [AW-1:0] addr,
    output logic [3:0]    wstrb,
    output logic [DW-1:0] wdata,
    input  logic          addr_ok,
    input  logic          data_ok,
    input  logic [DW-1:0] rdata
`ifdef DATA_SRAM_BRIDGE_ALIGN_CHECK_EN
    ,
    output logic          adel,
    output logic          ades
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    wstrb_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rbuf_q;

    logic          misaligned;
    logic          issue;
    logic [3:0]    strb_in;

    // Misalignment detection; compiled out, every access goes to the bus.
    always_comb begin
`ifdef DATA_SRAM_BRIDGE_ALIGN_CHECK_EN
        misaligned = ((sizeM == 2'd1) && aluoutM[0]) ||
                     ((sizeM == 2'd2) && (aluoutM[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        issue   = mem_enM && !misaligned;
        strb_in = memwriteM ? sig_write : 4'b0000;
    end

    // FSM and request/response registers: latch on issue, capture load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        wr_q    <= memwriteM;
                        size_q  <= sizeM;
                        addr_q  <= aluoutM;
                        wstrb_q <= strb_in;
                        wdata_q <= writedataM;
                        state_q <= addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (addr_ok) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (data_ok) begin
                        if (!wr_q) begin
                            rbuf_q <= rdata;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Hold here while the pipeline is frozen elsewhere so the
                    // same instruction is not re-issued.
                    if (!stall_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus and pipeline outputs: live M-stage fields in IDLE, latched copy after.
    always_comb begin
        req       = 1'b0;
        stall_mem = 1'b0;
        wr        = 1'b0;
        size      = 2'd0;
        addr      = '0;
        wstrb     = 4'b0000;
        wdata     = '0;
        if (rst) begin
            if (state_q == IDLE) begin
                req       = issue;
                stall_mem = issue;
                wr        = memwriteM;
                size      = sizeM;
                addr      = aluoutM;
                wstrb     = strb_in;
                wdata     = writedataM;
            end else begin
                req       = (state_q == ADDR);
                stall_mem = (state_q == ADDR) || (state_q == DATA);
                wr        = wr_q;
                size      = size_q;
                addr      = addr_q;
                wstrb     = wstrb_q;
                wdata     = wdata_q;
            end
        end
    end

    assign readdataM = rbuf_q;

`ifdef DATA_SRAM_BRIDGE_ALIGN_CHECK_EN
    // Address-error flags pulse only while the offending access is presented.
    always_comb begin
        adel = rst && (state_q == IDLE) && mem_enM && misaligned && !memwriteM;
        ades = rst && (state_q == IDLE) && mem_enM && misaligned && memwriteM;
    end
`endif

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Memory-stage data port adapter, directly downstream of the pipeline datapath.
- Consumes the M-stage access (memwriteM, sig_write, aluoutM, writedataM) and returns readdataM.
- Converts the single-cycle SRAM-style port into a split addr/data handshake bus (req/addr_ok/data_ok).
- Generates stall_mem to freeze the pipeline while a transaction is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width; fixed at 32 for MIPS word accesses

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (low = reset)
- mem_enM  in  1  M-stage instruction is a load/store
- memwriteM  in  1  1 = store, 0 = load
- sig_write  in  4  byte write strobes for stores
- sizeM  in  2  access size: 0 = byte, 1 = half, 2 = word
- aluoutM  in  AW  effective address
- writedataM  in  DW  store data, already lane-aligned
- stall_in  in  1  pipeline stalled by another source (e.g. divider)
- readdataM  out  DW  load data returned to the pipeline
- stall_mem  out  1  hold all stages while access is in flight
- req  out  1  bus request
- wr  out  1  bus write
- size  out  2  bus size
- addr  out  AW  bus address
- wstrb  out  4  bus byte enables
- wdata  out  DW  bus write data
- addr_ok  in  1  request accepted this cycle
- data_ok  in  1  response valid this cycle
- rdata  in  DW  response data

Behaviour:
- Reset (rst low, async): state=IDLE; req=0, wr=0, size=0, addr=0, wstrb=0, wdata=0, stall_mem=0, readdataM=0; latched request fields = 0.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - req = mem_enM (combinational). wr/size/addr/wstrb/wdata driven straight from the M-stage inputs; all fields latched on the same edge.
  - stall_mem = mem_enM.
  - mem_enM & addr_ok -> DATA. mem_enM & ~addr_ok -> ADDR.
- ADDR:
  - req=1; bus fields driven from the latched copy, stable until accepted; stall_mem=1.
  - addr_ok -> DATA.
- DATA:
  - req=0; stall_mem=1.
  - data_ok -> DONE. For loads, rdata is captured into the read buffer; for stores the buffer is unchanged.
- DONE:
  - stall_mem=0; readdataM = read buffer.
  - stall_in=1: remain in DONE, no new request issued for the same instruction.
  - stall_in=0: -> IDLE (the M stage advances on this edge).
- readdataM always equals the read buffer, in every state.
- Latency: minimum 2 stalled cycles (addr_ok in IDLE cycle, data_ok the next cycle); the result is visible in DONE.
- wstrb = sig_write for stores and 4'b0000 for loads.
- data_ok outside DATA and addr_ok outside IDLE/ADDR are ignored.
- One outstanding transaction maximum; no pipelining of requests.
- Reset mid-transaction aborts to IDLE; the bus slave shares rst and must drop the transaction.

Optional Feature:
- Macro: DATA_SRAM_BRIDGE_ALIGN_CHECK_EN.
- Enabled:
  - Adds outputs adel (load) and ades (store), 1 bit each, reset 0.
  - A misaligned access (sizeM=1 & aluoutM[0]; sizeM=2 & aluoutM[1:0]!=0) in IDLE issues no req and asserts stall_mem=0.
  - It pulses adel/ades for that cycle while mem_enM is high; state stays IDLE.
- Disabled:
  - Ports are absent; every access goes to the bus unchecked.

Test Plan:
- Load word: mem_enM=1, memwriteM=0, sizeM=2, aluoutM=0x80001000; addr_ok same cycle, data_ok next cycle with rdata=0xDEADBEEF -> req high 1 cycle, stall_mem high 2 cycles, readdataM=0xDEADBEEF in DONE.
- Byte store with backpressure: sig_write=4'b0100, writedataM=0x00AB0000; addr_ok withheld 3 cycles -> req held 4 cycles with addr/wstrb/wdata stable; stall_mem=1 until data_ok; readdataM unchanged.
- External stall in DONE: stall_in=1 for 2 cycles after data_ok -> state stays DONE, req=0, exactly one bus transaction counted; IDLE when stall_in drops.
- Back-to-back loads 0x10 then 0x14 -> two separate transactions, second req only after DONE->IDLE, readdataM updates per load.
- Async reset asserted in DATA -> req, stall_mem, readdataM go 0 immediately; state IDLE; later data_ok ignored.
- (ALIGN_CHECK_EN) sizeM=2, aluoutM=0x1002, load -> no req, adel=1 for one cycle, stall_mem=0.
